// File: rtl/child_resp_collector.sv
// Fan-in collector: round-robin arbitration of child response words into one
// registered, child-tagged output stage, with per-sweep completion tracking.
module child_resp_collector #(
    parameter  int NUM_CHILD = 5,
    parameter  int DATA_W    = 8,
    parameter  int CNT_W     = 16,
    localparam int CID_W     = $clog2(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [CID_W-1:0]            out_cid,
    input  logic                        out_ready,
    output logic                        sweep_done,
    output logic [CNT_W-1:0]            sweep_cnt
);

    localparam int IDX_W = CID_W + 1;

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic [CID_W-1:0]     out_cid_q, out_cid_d;
    logic [CID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CHILD-1:0] seen_mask_q, seen_mask_d;
    logic                 sweep_done_q, sweep_done_d;
    logic [CNT_W-1:0]     sweep_cnt_q, sweep_cnt_d;

    logic [DATA_W-1:0]    child_word [NUM_CHILD];
    logic [IDX_W-1:0]     cand_sum   [NUM_CHILD];
    logic [CID_W-1:0]     cand_idx   [NUM_CHILD];
    logic [NUM_CHILD-1:0] cand_valid;
    logic [NUM_CHILD-1:0] grant_onehot;
    logic [NUM_CHILD-1:0] seen_set;
    logic                 grant_found;
    logic [CID_W-1:0]     grant_idx;
    logic                 load;
    logic                 accept;
    logic                 sweep_complete;

    // Candidate gi is the child gi positions after rr_ptr, wrapped into range.
    for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_cand
        assign child_word[gi] = child_data[gi*DATA_W +: DATA_W];
        assign cand_sum[gi]   = {1'b0, rr_ptr_q} + IDX_W'(gi);
        always_comb begin
            cand_idx[gi] = cand_sum[gi][CID_W-1:0];
            if (cand_sum[gi] >= IDX_W'(NUM_CHILD)) begin
                cand_idx[gi] = cand_sum[gi][CID_W-1:0] - CID_W'(NUM_CHILD);
            end
        end
        assign cand_valid[gi] = child_valid[cand_idx[gi]];
    end

    // Scan from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_CHILD - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign load   = ~out_valid_q | out_ready;
    assign accept = grant_found & load & ~rst;

    for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_onehot
        assign grant_onehot[gi] = grant_found && (grant_idx == CID_W'(gi));
    end

    assign child_ready    = grant_onehot & {NUM_CHILD{load & ~rst}};
    assign seen_set       = seen_mask_q | grant_onehot;
    assign sweep_complete = accept & (&seen_set);

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_cid_d    = out_cid_q;
        rr_ptr_d     = rr_ptr_q;
        seen_mask_d  = seen_mask_q;
        sweep_done_d = 1'b0;
        sweep_cnt_d  = sweep_cnt_q;
        if (load) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = child_word[grant_idx];
                out_cid_d  = grant_idx;
                rr_ptr_d   = (grant_idx == CID_W'(NUM_CHILD - 1)) ? '0 : grant_idx + 1'b1;
                if (sweep_complete) begin
                    seen_mask_d  = '0;
                    sweep_done_d = 1'b1;
                    sweep_cnt_d  = sweep_cnt_q + 1'b1;
                end else begin
                    seen_mask_d  = seen_set;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_cid_q    <= '0;
            rr_ptr_q     <= '0;
            seen_mask_q  <= '0;
            sweep_done_q <= 1'b0;
            sweep_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_cid_q    <= out_cid_d;
            rr_ptr_q     <= rr_ptr_d;
            seen_mask_q  <= seen_mask_d;
            sweep_done_q <= sweep_done_d;
            sweep_cnt_q  <= sweep_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_cid    = out_cid_q;
    assign sweep_done = sweep_done_q;
    assign sweep_cnt  = sweep_cnt_q;

endmodule
